// File: rtl/add_rr_scheduler_if.sv
// Request/grant/sequencing bundle between the shared-adder scheduler and the
// requester front-ends plus adder datapath (operand mux, operand/result regs).
// master: scheduler side (drives grant/strobes); slave: requesters/datapath side.
interface add_rr_scheduler_if;
    logic [3:0] req;            // level request per requester
    logic [1:0] sel;            // granted requester, operand mux select
    logic       load_operands;  // pulse: capture operands chosen by sel
    logic       write_result;   // pulse: write adder result for requester sel
    logic [3:0] ack;            // one-hot pulse on bit sel with write_result
    logic       busy;           // scheduler not idle
    logic [5:0] op_count;       // completed operations, wraps at 64
    logic       wrap;           // pulse on the write that takes op_count 63->0

    modport master (
        input  req,
        output sel, load_operands, write_result, ack, busy, op_count, wrap
    );

    modport slave (
        output req,
        input  sel, load_operands, write_result, ack, busy, op_count, wrap
    );
endinterface

// File: rtl/add_rr_scheduler.sv
// Round-robin scheduler sharing one adder datapath among four requesters.
// Latency: CAL_CYCLES+3 cycles from request sampled in IDLE to ack.
// Backpressure: requesters hold req until ack; req only sampled in IDLE.
// Ports: clk, rst (sync active-high), bus (add_rr_scheduler_if.master):
//   req in; sel, load_operands, write_result, ack, busy, op_count, wrap out.
module add_rr_scheduler #(
    parameter int unsigned CAL_CYCLES = 2   // adder settle cycles, 1..15
) (
    input  logic                  clk,
    input  logic                  rst,
    add_rr_scheduler_if.master    bus
);

    typedef enum logic [1:0] {IDLE, LOAD, CAL, WRITE} state_t;

    localparam logic [3:0] CAL_LAST = 4'(CAL_CYCLES - 1);

    state_t     state, state_nxt;
    logic [1:0] sel_q, sel_nxt;
    logic [1:0] last_grant, last_nxt;
    logic [5:0] op_count_q, op_count_nxt;
    logic [3:0] cal_cnt, cal_nxt;
    logic [1:0] winner;
    logic       found;
    logic [1:0] idx;

    // Scan from last_grant+1 upward; the k=4 step revisits last_grant itself,
    // so the requester just served is always checked last.
    always_comb begin
        winner = last_grant;
        found  = 1'b0;
        idx    = last_grant;
        for (int k = 1; k <= 4; k++) begin
            idx = last_grant + 2'(k);
            if (!found && bus.req[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt    = state;
        sel_nxt      = sel_q;
        last_nxt     = last_grant;
        op_count_nxt = op_count_q;
        cal_nxt      = cal_cnt;
        case (state)
            IDLE: begin
                if (|bus.req) begin
                    sel_nxt   = winner;
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                cal_nxt   = 4'd0;
                state_nxt = CAL;
            end
            CAL: begin
                cal_nxt = cal_cnt + 4'd1;
                if (cal_cnt == CAL_LAST) begin
                    state_nxt = WRITE;
                end
            end
            WRITE: begin
                op_count_nxt = op_count_q + 6'd1;
                last_nxt     = sel_q;
                state_nxt    = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // last_grant resets to 3 so requester 0 wins the first arbitration.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            sel_q      <= 2'd0;
            last_grant <= 2'd3;
            op_count_q <= 6'd0;
            cal_cnt    <= 4'd0;
        end else begin
            state      <= state_nxt;
            sel_q      <= sel_nxt;
            last_grant <= last_nxt;
            op_count_q <= op_count_nxt;
            cal_cnt    <= cal_nxt;
        end
    end

    assign bus.sel           = sel_q;
    assign bus.load_operands = (state == LOAD);
    assign bus.write_result  = (state == WRITE);
    assign bus.ack           = (state == WRITE) ? (4'b0001 << sel_q) : 4'b0000;
    assign bus.busy          = (state != IDLE);
    assign bus.op_count      = op_count_q;
    assign bus.wrap          = (state == WRITE) && (op_count_q == 6'd63);

endmodule

// File: doc/add_rr_scheduler.md
# add_rr_scheduler

Round-robin scheduler that shares the single ripple-carry adder datapath among four requesters. It grants one requester at a time and drives the operand mux select. It then sequences operand load, a fixed calculation wait and result write-back, and acknowledges the granted requester. It sits between the requester front-ends and the adder datapath's operand register, result register and mux-select inputs, and replaces the single-stream line sequencer when the adder is shared.

## Interface
Parameters:
- CAL_CYCLES, default 2, number of cycles the adder result needs to settle after operand load; legal range 1..15.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- req  input  4  request lines, one per requester; level-sensitive.
- sel  output  2  index of the granted requester; drives the operand mux; registered.
- load_operands  output  1  one-cycle pulse; the datapath captures the operands selected by sel.
- write_result  output  1  one-cycle pulse; the datapath writes the adder result back for requester sel.
- ack  output  4  one-hot pulse on bit sel, coincident with write_result.
- busy  output  1  high whenever the FSM is not in IDLE.
- op_count  output  6  completed-operation counter; wraps.
- wrap  output  1  one-cycle pulse, coincident with the write_result that takes op_count from 63 to 0.

## Operation
FSM states: IDLE, LOAD, CAL, WRITE. All outputs except sel and op_count are decoded from the current state (Moore outputs).
- IDLE
  - busy=0.
  - If req!=0, select a winner by round robin and register it into sel; next state LOAD.
  - Otherwise stay in IDLE; sel holds its value.
- LOAD
  - load_operands=1; cal_cnt<=0; next state CAL.
- CAL
  - cal_cnt increments each cycle.
  - Leave for WRITE in the cycle where cal_cnt==CAL_CYCLES-1, so CAL lasts exactly CAL_CYCLES cycles.
- WRITE
  - write_result=1, ack[sel]=1.
  - op_count<=op_count+1 (6-bit, 63 wraps to 0); wrap=1 when op_count==63.
  - last_grant<=sel; next state IDLE.

Round-robin rule:
- Priority order is last_grant+1, +2, +3, +4 (mod 4); the first asserted req in that order wins.
- A requester that was just served has the lowest priority in the next arbitration.

Request rules:
- Requesters hold req until they see ack, and drop it in the cycle after ack.
- A req still high in the IDLE cycle after the ack counts as a new request.
- req is sampled only in IDLE. Changes during LOAD, CAL or WRITE have no effect, and a granted operation completes even if its req drops mid-operation.

Reset:
- state=IDLE, sel=0, last_grant=3 (so requester 0 has top priority after reset), op_count=0, cal_cnt=0.
- All pulses (load_operands, write_result, ack, wrap) and busy are 0.
- Reset mid-operation aborts the operation immediately: no ack or write_result is produced for it.

## Timing
- Operation length: 1 (IDLE arbitration) + 1 (LOAD) + CAL_CYCLES (CAL) + 1 (WRITE) = CAL_CYCLES+3 cycles, request to ack. For CAL_CYCLES=2 this is 5 cycles.
- Example, CAL_CYCLES=2, req rising before edge 0 in IDLE:
  - sel valid and load_operands high after edge 0.
  - CAL after edges 1 and 2.
  - write_result and ack high after edge 3.
  - busy falls after edge 4.
- Back-to-back requests: one IDLE cycle separates operations, so throughput is one operation every CAL_CYCLES+3 cycles.
- sel is stable from LOAD through WRITE and changes only on the transition from IDLE to LOAD.
- If rst and any state transition occur in the same cycle, rst wins.

## Test plan
- Reset: assert rst for 2 cycles with req=4'b1111 -> all outputs 0, sel=0, busy=0; after release the first grant is sel=0.
- Single request: req=4'b0100, CAL_CYCLES=2 -> load_operands at cycle 1, ack=4'b0100 with write_result at cycle 4, op_count=1, sel=2 held for cycles 1..4.
- Fairness: req=4'b1111 held continuously -> grant order 0,1,2,3,0,… with acks spaced 5 cycles apart.
- Lowest priority after service: sequence 0 then 2 with req=4'b0101 held -> next grant is 0, not 2.
- Mid-operation events:
  - req drops during CAL -> ack still issued.
  - rst asserted during CAL -> no ack, state IDLE, op_count=0.
- Wrap: complete 64 operations -> op_count returns to 0, wrap pulses exactly once, on the 64th write_result.
- Parameter: rerun the single-request test with CAL_CYCLES=1 and 15 -> ack at cycles 3 and 17 respectively.
